// File: rtl/icache_tag_sram_multiway_ctrl.sv
// rtl/icache_tag_sram_multiway_ctrl.sv - multi-way L1.5 icache tag store with init/flush FSM
// Optional per-entry even parity when ICACHE_TAG_PARITY_EN is defined.
module icache_tag_sram_multiway_ctrl #(
  parameter int unsigned BehavMem = 1,
  parameter int unsigned NumWays  = 4,
  parameter int unsigned NumWords = 64,
  parameter int unsigned TagWidth = 8,
  localparam int unsigned AW = $clog2(NumWords)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_req_i,
  output logic                         flush_ack_o,
  output logic                         init_busy_o,
  input  logic                         req_i,
  output logic                         gnt_o,
  input  logic                         we_i,
  input  logic [NumWays-1:0]           way_be_i,
  input  logic [AW-1:0]                addr_i,
  input  logic [TagWidth-1:0]          wdata_i,
  output logic [NumWays*TagWidth-1:0]  rdata_o,
  output logic                         rvalid_o,
  output logic [NumWays-1:0]           parity_err_o
);

`ifdef ICACHE_TAG_PARITY_EN
  localparam int unsigned BankWidth = TagWidth + 1;
`else
  localparam int unsigned BankWidth = TagWidth;
`endif
  localparam logic [AW-1:0] LastIdx = AW'(NumWords - 1);

  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  state_e               state;
  logic [AW-1:0]        cnt;
  logic                 flush_run;
  logic                 rd_en;
  logic                 bank_req;
  logic [NumWays-1:0]   bank_we;
  logic [AW-1:0]        bank_addr;
  logic [BankWidth-1:0] bank_wdata;
  logic [BankWidth-1:0] wdata_ext;

`ifdef ICACHE_TAG_PARITY_EN
  assign wdata_ext = {^wdata_i, wdata_i};
`else
  assign wdata_ext = wdata_i;
`endif

  assign gnt_o       = (state == ST_IDLE) & req_i & ~flush_req_i;
  assign rd_en       = gnt_o & ~we_i;
  assign init_busy_o = (state == ST_INIT);
  // Only a flush-triggered clear is acknowledged; reset clears flush_run.
  assign flush_ack_o = (state == ST_INIT) & (cnt == LastIdx) & flush_run;

  always_comb begin
    bank_req   = 1'b0;
    bank_we    = '0;
    bank_addr  = addr_i;
    bank_wdata = wdata_ext;
    if (state == ST_INIT) begin
      bank_req   = 1'b1;
      bank_we    = '1;
      bank_addr  = cnt;
      bank_wdata = '0;
    end else if (gnt_o) begin
      bank_req = 1'b1;
      bank_we  = we_i ? way_be_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_INIT;
      cnt       <= '0;
      flush_run <= 1'b0;
      rvalid_o  <= 1'b0;
    end else begin
      rvalid_o <= rd_en;
      case (state)
        ST_INIT: begin
          if (cnt == LastIdx) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            flush_run <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (flush_req_i) begin
            state     <= ST_INIT;
            cnt       <= '0;
            flush_run <= 1'b1;
          end
        end
      endcase
    end
  end

  for (genvar w = 0; w < NumWays; w++) begin : g_way
    logic [BankWidth-1:0] mem [NumWords];
    logic [BankWidth-1:0] rdata_q;

    if (BehavMem != 0) begin : g_behav
      always_ff @(posedge clk_i) begin
        if (bank_req && bank_we[w]) mem[bank_addr] <= bank_wdata;
      end
    end else begin : g_macro
      // Macro-style bank: byte-masked write with all bytes enabled.
      localparam int unsigned BeWidth = (BankWidth + 7) / 8;
      logic [BeWidth-1:0]   bank_be;
      logic [BankWidth-1:0] bit_mask;
      assign bank_be = '1;
      always_comb begin
        bit_mask = '0;
        for (int i = 0; i < BankWidth; i++) bit_mask[i] = bank_be[i>>3];
      end
      always_ff @(posedge clk_i) begin
        if (bank_req && bank_we[w])
          mem[bank_addr] <= (mem[bank_addr] & ~bit_mask) | (bank_wdata & bit_mask);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rdata_q <= '0;
      else if (rd_en) rdata_q <= mem[addr_i];
    end

    assign rdata_o[w*TagWidth +: TagWidth] = rdata_q[TagWidth-1:0];
`ifdef ICACHE_TAG_PARITY_EN
    assign parity_err_o[w] = rvalid_o & (rdata_q[TagWidth] ^ (^rdata_q[TagWidth-1:0]));
`else
    assign parity_err_o[w] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_icache_tag_sram_multiway_ctrl.sv
// tb/tb_icache_tag_sram_multiway_ctrl.sv - directed bench for icache_tag_sram_multiway_ctrl
// Table-driven access vectors plus hand sequences for init, flush and reset.
module tb_icache_tag_sram_multiway_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_req;
  logic        flush_ack;
  logic        init_busy;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  way_be;
  logic [5:0]  addr;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic [3:0]  parity_err;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  icache_tag_sram_multiway_ctrl #(
    .BehavMem(1), .NumWays(4), .NumWords(64), .TagWidth(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_req_i(flush_req), .flush_ack_o(flush_ack),
    .init_busy_o(init_busy), .req_i(req), .gnt_o(gnt), .we_i(we), .way_be_i(way_be),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .rvalid_o(rvalid),
    .parity_err_o(parity_err)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string name, input logic [5:0] a, input logic [31:0] exp);
    req = 1'b1; we = 1'b0; addr = a; way_be = 4'h0;
    #1 check({name, "_gnt"}, gnt, 1);
    step();
    req = 1'b0;
    check({name, "_rvalid"}, rvalid, 1);
    check({name, "_rdata"}, rdata, exp);
  endtask

  task automatic run_init(output int cycles, output int acks, output int ack_at,
                          output int rv, output int gn);
    cycles = 0; acks = 0; ack_at = 0; rv = 0; gn = 0;
    while (init_busy && cycles < 200) begin
      cycles++;
      if (flush_ack) begin acks++; ack_at = cycles; end
      if (rvalid) rv++;
      if (gnt) gn++;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cyc, acks, ack_at, rv, gn;

    vecs[0]  = '{1'b1, 4'b0010, 6'd5,  8'hA5, 32'h00000000};
    vecs[1]  = '{1'b0, 4'b0000, 6'd5,  8'h00, 32'h0000A500};
    vecs[2]  = '{1'b1, 4'b1111, 6'd63, 8'h3C, 32'h0000A500};
    vecs[3]  = '{1'b1, 4'b0101, 6'd0,  8'h81, 32'h0000A500};
    vecs[4]  = '{1'b0, 4'b0000, 6'd63, 8'h00, 32'h3C3C3C3C};
    vecs[5]  = '{1'b0, 4'b0000, 6'd0,  8'h00, 32'h00810081};
    vecs[6]  = '{1'b0, 4'b0000, 6'd5,  8'h00, 32'h0000A500};
    vecs[7]  = '{1'b1, 4'b1000, 6'd5,  8'h7E, 32'h0000A500};
    vecs[8]  = '{1'b0, 4'b0000, 6'd5,  8'h00, 32'h7E00A500};
    vecs[9]  = '{1'b0, 4'b0000, 6'd1,  8'h00, 32'h00000000};
    vecs[10] = '{1'b1, 4'b1111, 6'd9,  8'h5A, 32'h00000000};
    vecs[11] = '{1'b0, 4'b0000, 6'd9,  8'h00, 32'h5A5A5A5A};
    vecs[12] = '{1'b1, 4'b0000, 6'd17, 8'hFF, 32'h5A5A5A5A};
    vecs[13] = '{1'b0, 4'b0000, 6'd17, 8'h00, 32'h00000000};

    // T1: reset state and reset-triggered init, with req held high
    rst_n = 1'b0; flush_req = 1'b0; req = 1'b1; we = 1'b0;
    way_be = 4'h0; addr = 6'd0; wdata = 8'h00;
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_flush_ack", flush_ack, 0);
    check("rst_parity", parity_err, 0);
    check("rst_init_busy", init_busy, 1);
    #10 rst_n = 1'b1;
    run_init(cyc, acks, ack_at, rv, gn);
    check("t1_init_cycles", cyc, 64);
    check("t1_no_ack", acks, 0);
    check("t1_no_gnt", gn, 0);
    check("t1_no_rvalid", rv, 0);
    req = 1'b0;
    do_read("t1_rd17", 6'd17, 32'h0);

    // T2/T3: back-to-back table of writes and reads
    for (int i = 0; i < 14; i++) begin
      req = 1'b1; we = vecs[i].we; way_be = vecs[i].be;
      addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1 check($sformatf("v%0d_gnt", i), gnt, 1);
      step();
      check($sformatf("v%0d_rvalid", i), rvalid, !vecs[i].we);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_parity", i), parity_err, 0);
    end
    req = 1'b0; we = 1'b0;
    step();
    check("idle_rvalid_pulse", rvalid, 0);
    check("idle_rdata_hold", rdata, 0);

    // T6: parity on idx 9 (way 2 bit 3 corrupted only when parity is built in)
`ifdef ICACHE_TAG_PARITY_EN
    dut.g_way[2].mem[9] = dut.g_way[2].mem[9] ^ 9'h008;
    req = 1'b1; we = 1'b0; addr = 6'd9;
    #1 step();
    req = 1'b0;
    check("t6_rvalid", rvalid, 1);
    check("t6_parity", parity_err, 4'b0100);
    check("t6_rdata", rdata, 32'h5A525A5A);
`else
    req = 1'b1; we = 1'b0; addr = 6'd9;
    #1 step();
    req = 1'b0;
    check("t6_rvalid", rvalid, 1);
    check("t6_parity", parity_err, 4'b0000);
    check("t6_rdata", rdata, 32'h5A5A5A5A);
`endif

    // T4: flush beats a same-cycle read request
    req = 1'b1; we = 1'b0; addr = 6'd5; flush_req = 1'b1;
    #1 check("t4_gnt_blocked", gnt, 0);
    step();
    flush_req = 1'b0; req = 1'b0;
    check("t4_no_rvalid", rvalid, 0);
    check("t4_busy", init_busy, 1);
    run_init(cyc, acks, ack_at, rv, gn);
    check("t4_init_cycles", cyc, 64);
    check("t4_ack_count", acks, 1);
    check("t4_ack_cycle", ack_at, 64);
    do_read("t4_rd5", 6'd5, 32'h0);
    do_read("t4_rd63", 6'd63, 32'h0);

    // T5a: reset at cnt=20 of a flush restarts a full, unacknowledged init
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (20) step();
    rst_n = 1'b0;
    #2 check("t5_busy_in_rst", init_busy, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    run_init(cyc, acks, ack_at, rv, gn);
    check("t5_init_cycles", cyc, 64);
    check("t5_no_ack", acks, 0);

    // T5b: reset while a read is in flight drops its response
    req = 1'b1; we = 1'b1; way_be = 4'b1111; addr = 6'd7; wdata = 8'hC3;
    #1 step();
    we = 1'b0;
    #1 check("t5_rd_gnt", gnt, 1);
    rst_n = 1'b0;
    #1 check("t5_rvalid_rst", rvalid, 0);
    @(posedge clk); #1;
    check("t5_rvalid_edge", rvalid, 0);
    rst_n = 1'b1; req = 1'b0;
    run_init(cyc, acks, ack_at, rv, gn);
    check("t5_rvalid_never", rv, 0);
    check("t5_init_cycles2", cyc, 64);
    do_read("t5_rd7", 6'd7, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
